// File: rtl/transfer_samples_seq.sv
// transfer_samples_seq: sequences one ADC sample transfer per RDY request.
// A transfer is: WAIT (pre-read settle), L1A_RD (L1A FIFO pop), STRT, then
// NCHIP RD_ENA cycles per enabled channel, with one NEXT_CH cycle between
// channels. Requests that arrive while a transfer runs are queued in a
// saturating pending counter. If that counter is full, OVR is set.
// All outputs are flops that carry the values of the state being occupied.
module transfer_samples_seq #(
    parameter int NCHAN    = 16,
    parameter int NCHIP    = 6,
    parameter int WAIT_CNT = 4,
    parameter int L1A_CNT  = 2,
    parameter int PDEPTH   = 7
) (
    input  logic             CLK,
    input  logic             RST_B,
    input  logic             RDY,
    input  logic             JTAG_MODE,
    input  logic [NCHAN-1:0] CHAN_MASK,
    input  logic             OVR_CLR,
    output logic [3:0]       CHAN,
    output logic [2:0]       CHIP,
    output logic             L1A_RD_EN,
    output logic             RDENA,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVR,
    output logic [2:0]       XSTATE
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_NEXT_CH = 3'd1,
        S_L1A_RD  = 3'd2,
        S_RD_ENA  = 3'd3,
        S_STRT    = 3'd4,
        S_WAIT    = 3'd5
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(WAIT_CNT - 1);
    localparam logic [15:0] L1A_LAST  = 16'(L1A_CNT - 1);
    localparam logic [15:0] CHIP_LAST = 16'(NCHIP - 1);
    localparam logic [3:0]  PEND_MAX  = 4'(PDEPTH);

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [4:0] find_chan(input logic [NCHAN-1:0] mask,
                                             input logic [4:0]       from);
        logic [4:0] res;
        res = 5'd0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            res = (mask[i] && (5'(i) >= from)) ? {1'b1, 4'(i)} : res;
        end
        return res;
    endfunction

    state_t           r_state;
    logic [15:0]      r_cnt;
    logic [NCHAN-1:0] r_mask;
    logic [3:0]       r_pend;
    logic             r_ovr;
    logic [3:0]       r_chan;
    logic [2:0]       r_chip;
    logic             r_l1a;
    logic             r_rdena;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [15:0]      w_cnt_nxt;
    logic [3:0]       w_chan_nxt;
    logic             w_start_req;
    logic             w_start;
    logic             w_done_nxt;
    logic             w_rd_nxt;
    logic             w_ovr_set;
    logic [4:0]       w_first;
    logic [4:0]       w_next;

    // Start condition and channel search over the captured mask.
    always_comb begin
        w_start_req = (RDY || (r_pend != 4'd0)) && !JTAG_MODE &&
                      (CHAN_MASK != {NCHAN{1'b0}});
        w_first     = find_chan(r_mask, 5'd0);
        w_next      = find_chan(r_mask, {1'b0, r_chan} + 5'd1);
    end

    // Next-state, counter and next-output logic of the transfer sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_chan_nxt  = r_chan;
        w_start     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 16'd0;
                if (w_start_req) begin
                    w_state_nxt = S_WAIT;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == WAIT_LAST) begin
                    w_state_nxt = S_L1A_RD;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 16'd1;
                end
            end
            S_L1A_RD: begin
                if (r_cnt == L1A_LAST) begin
                    w_state_nxt = S_STRT;
                    w_cnt_nxt   = 16'd0;
                    w_chan_nxt  = w_first[4] ? w_first[3:0] : 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 16'd1;
                end
            end
            S_STRT: begin
                w_state_nxt = S_RD_ENA;
                w_cnt_nxt   = 16'd0;
            end
            S_RD_ENA: begin
                if (r_cnt == CHIP_LAST) begin
                    w_cnt_nxt = 16'd0;
                    if (w_next[4]) begin
                        w_state_nxt = S_NEXT_CH;
                        w_chan_nxt  = w_next[3:0];
                    end else begin
                        // Last read of the transfer: DONE follows, and a
                        // queued request may restart without passing IDLE.
                        w_done_nxt = 1'b1;
                        if (w_start_req) begin
                            w_state_nxt = S_WAIT;
                            w_start     = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_NEXT_CH: begin
                w_state_nxt = S_RD_ENA;
                w_cnt_nxt   = 16'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
        w_rd_nxt  = (w_state_nxt == S_STRT) || (w_state_nxt == S_RD_ENA) ||
                    (w_state_nxt == S_NEXT_CH);
        w_ovr_set = RDY && !w_start && (r_pend == PEND_MAX);
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_chan  <= 4'd0;
            r_chip  <= 3'd0;
            r_l1a   <= 1'b0;
            r_rdena <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chan  <= w_rd_nxt ? w_chan_nxt : 4'd0;
            r_chip  <= (w_state_nxt == S_RD_ENA) ? w_cnt_nxt[2:0] : 3'd0;
            r_l1a   <= (w_state_nxt == S_L1A_RD);
            r_rdena <= w_rd_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    // Channel mask is frozen at transfer start for the whole transfer.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_mask <= {NCHAN{1'b0}};
        end else if (w_start) begin
            r_mask <= CHAN_MASK;
        end else begin
            r_mask <= r_mask;
        end
    end

    // Pending request counter and sticky overflow flag (set beats clear).
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_pend <= 4'd0;
            r_ovr  <= 1'b0;
        end else begin
            if (RDY && !w_start) begin
                r_pend <= (r_pend == PEND_MAX) ? r_pend : r_pend + 4'd1;
            end else if (!RDY && w_start) begin
                r_pend <= r_pend - 4'd1;
            end else begin
                r_pend <= r_pend;
            end
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (OVR_CLR) begin
                r_ovr <= 1'b0;
            end else begin
                r_ovr <= r_ovr;
            end
        end
    end

    assign CHAN      = r_chan;
    assign CHIP      = r_chip;
    assign L1A_RD_EN = r_l1a;
    assign RDENA     = r_rdena;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign OVR       = r_ovr;
    assign XSTATE    = r_state;

endmodule

// File: tb/tb_transfer_samples_seq.sv
// Testbench for transfer_samples_seq with default parameters. A queue-based
// reference model expands each transfer into its expected per-cycle outputs
// and is compared against the DUT every cycle. Table-driven mask checks and
// hand-written corner sequences are added on top of that comparison.
module tb_transfer_samples_seq;

    localparam int NCHIP  = 6;
    localparam int WAITN  = 4;
    localparam int L1AN   = 2;
    localparam int PDEPTH = 7;

    logic        CLK = 1'b0;
    logic        RST_B;
    logic        RDY;
    logic        JTAG_MODE;
    logic [15:0] CHAN_MASK;
    logic        OVR_CLR;
    logic [3:0]  CHAN;
    logic [2:0]  CHIP;
    logic        L1A_RD_EN;
    logic        RDENA;
    logic        BUSY;
    logic        DONE;
    logic        OVR;
    logic [2:0]  XSTATE;

    transfer_samples_seq dut (
        .CLK       (CLK),
        .RST_B     (RST_B),
        .RDY       (RDY),
        .JTAG_MODE (JTAG_MODE),
        .CHAN_MASK (CHAN_MASK),
        .OVR_CLR   (OVR_CLR),
        .CHAN      (CHAN),
        .CHIP      (CHIP),
        .L1A_RD_EN (L1A_RD_EN),
        .RDENA     (RDENA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OVR       (OVR),
        .XSTATE    (XSTATE)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Expected outputs for one cycle; 'last' marks the final read of a transfer.
    typedef struct packed {
        logic [2:0] st;
        logic [3:0] chan;
        logic [2:0] chip;
        logic       l1a;
        logic       rdena;
        logic       busy;
        logic       done;
        logic       last;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    int   m_pend;
    logic m_ovr;

    typedef struct {
        logic [15:0] mask;
        int          cycles;
        int          first_ch;
        int          last_ch;
    } row_t;

    row_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic [2:0] st, input int ch, input int cp, input logic last);
        rec_t r;
        r.st    = st;
        r.chan  = 4'(ch);
        r.chip  = 3'(cp);
        r.l1a   = (st == 3'd2);
        r.rdena = (st == 3'd4) || (st == 3'd3) || (st == 3'd1);
        r.busy  = (st != 3'd0);
        r.done  = 1'b0;
        r.last  = last;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        cur    = mk(3'd0, 0, 0, 1'b0);
        m_pend = 0;
        m_ovr  = 1'b0;
    endtask

    // Expand one whole transfer for the given mask into the expectation queue.
    task automatic model_build(input logic [15:0] mask);
        int chans[$];
        for (int i = 0; i < 16; i++) if (mask[i]) chans.push_back(i);
        for (int i = 0; i < WAITN; i++) q.push_back(mk(3'd5, 0, 0, 1'b0));
        for (int i = 0; i < L1AN; i++) q.push_back(mk(3'd2, 0, 0, 1'b0));
        q.push_back(mk(3'd4, chans[0], 0, 1'b0));
        for (int k = 0; k < chans.size(); k++) begin
            for (int j = 0; j < NCHIP; j++)
                q.push_back(mk(3'd3, chans[k], j, (k == chans.size() - 1) && (j == NCHIP - 1)));
            if (k < chans.size() - 1) q.push_back(mk(3'd1, chans[k+1], 0, 1'b0));
        end
    endtask

    task automatic model_step();
        logic start, ovr_set, done_n;
        start   = (q.size() == 0) && (RDY || m_pend > 0) && !JTAG_MODE && (CHAN_MASK != 16'h0);
        ovr_set = RDY && !start && (m_pend == PDEPTH);
        if (RDY && !start) begin
            if (m_pend < PDEPTH) m_pend++;
        end else if (!RDY && start) begin
            m_pend--;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (OVR_CLR) m_ovr = 1'b0;
        done_n = cur.last;
        if (start) model_build(CHAN_MASK);
        if (q.size() > 0) cur = q.pop_front();
        else cur = mk(3'd0, 0, 0, 1'b0);
        cur.done = done_n;
    endtask

    function automatic int act_pack();
        return int'({XSTATE, CHAN, CHIP, L1A_RD_EN, RDENA, BUSY, DONE, OVR});
    endfunction

    function automatic int exp_pack();
        return int'({cur.st, cur.chan, cur.chip, cur.l1a, cur.rdena, cur.busy, cur.done, m_ovr});
    endfunction

    // One clock: model advances at the edge, outputs compared half a cycle later.
    task automatic tick();
        @(posedge CLK);
        if (!RST_B) model_reset();
        else model_step();
        @(negedge CLK);
        chk("cycle", act_pack(), exp_pack());
    endtask

    task automatic run_to_done();
        int found;
        found = 0;
        for (int n = 0; n < 400 && found == 0; n++) begin
            tick();
            if (DONE) found = 1;
        end
        chk("run_done", found, 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, busy_cnt, done_at, l1a_at, first_ch, last_ch, dones, idle_gap, found;

        tbl[0] = '{16'hFFFF, 118, 0, 15};
        tbl[1] = '{16'h8001,  20, 0, 15};
        tbl[2] = '{16'h0001,  13, 0, 0};
        tbl[3] = '{16'h8000,  13, 15, 15};
        tbl[4] = '{16'h00F0,  34, 4, 7};
        tbl[5] = '{16'hAAAA,  62, 1, 15};

        RST_B = 1'b0; RDY = 1'b0; JTAG_MODE = 1'b0; CHAN_MASK = 16'h0; OVR_CLR = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("reset_state", act_pack(), 0);
        RST_B = 1'b1;
        repeat (2) tick();

        // Table-driven single transfers over several masks.
        for (int r = 0; r < 6; r++) begin
            CHAN_MASK = tbl[r].mask;
            RDY = 1'b1;
            n = 0; busy_cnt = 0; done_at = 0; l1a_at = 0; first_ch = -1; last_ch = -1;
            while (done_at == 0 && n < 400) begin
                tick();
                RDY = 1'b0;
                n++;
                if (BUSY) busy_cnt++;
                if (L1A_RD_EN && l1a_at == 0) l1a_at = n;
                if (XSTATE == 3'd4) first_ch = int'(CHAN);
                if (RDENA) last_ch = int'(CHAN);
                if (DONE) done_at = n;
            end
            chk("done_at", done_at, tbl[r].cycles + 1);
            chk("busy_cycles", busy_cnt, tbl[r].cycles);
            chk("l1a_first", l1a_at, WAITN + 1);
            chk("first_chan", first_ch, tbl[r].first_ch);
            chk("last_chan", last_ch, tbl[r].last_ch);
            repeat (2) tick();
        end

        // Overflow: one start plus eight queued pulses, then seven back-to-back.
        CHAN_MASK = 16'h0001;
        RDY = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) tick();
        RDY = 1'b0;
        chk("ovr_set", int'(OVR), 1);
        dones = 0; idle_gap = 0; found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            tick();
            if (DONE) dones++;
            if (!BUSY && !DONE) idle_gap++;
            if (DONE && !BUSY) found = 1;
        end
        chk("ovr_transfers", dones, 8);
        chk("ovr_no_idle", idle_gap, 0);
        chk("ovr_sticky", int'(OVR), 1);
        OVR_CLR = 1'b1;
        tick();
        OVR_CLR = 1'b0;
        chk("ovr_clr", int'(OVR), 0);

        // JTAG mode holds the request in IDLE; release starts on the next clock.
        JTAG_MODE = 1'b1;
        RDY = 1'b1;
        tick();
        RDY = 1'b0;
        repeat (3) tick();
        chk("jtag_hold", int'(XSTATE), 0);
        JTAG_MODE = 1'b0;
        tick();
        chk("jtag_release", int'(XSTATE), 5);
        run_to_done();

        // Zero mask also holds the request.
        CHAN_MASK = 16'h0;
        RDY = 1'b1;
        tick();
        RDY = 1'b0;
        tick();
        chk("mask0_hold", int'(BUSY), 0);
        CHAN_MASK = 16'h0010;
        tick();
        chk("mask_release", int'(XSTATE), 5);
        run_to_done();
        tick();

        // Asynchronous reset during RD_ENA with one request queued.
        CHAN_MASK = 16'hFFFF;
        RDY = 1'b1;
        tick();
        tick();
        RDY = 1'b0;
        found = 0;
        for (int k = 0; k < 50 && found == 0; k++) begin
            tick();
            if (XSTATE == 3'd3) found = 1;
        end
        chk("reach_rd_ena", found, 1);
        #2 RST_B = 1'b0;
        #1 chk("async_reset", act_pack(), 0);
        model_reset();
        repeat (2) tick();
        RST_B = 1'b1;
        repeat (5) tick();
        chk("post_reset_idle", int'(BUSY), 0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 2500; k++) begin
            RDY     = ($urandom_range(0, 39) == 0);
            OVR_CLR = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 59) == 0) JTAG_MODE = ~JTAG_MODE;
            if ($urandom_range(0, 149) == 0) begin
                if ($urandom_range(0, 7) == 0) CHAN_MASK = 16'h0;
                else CHAN_MASK = 16'($urandom & $urandom);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/transfer_samples_seq.md
TRANSFER_SAMPLES_SEQ -- requirements
Module: transfer_samples_seq

Interface
REQ-001 Parameter NCHAN, default 16, number of ADC channels per transfer (legal 2..16).
REQ-002 Parameter NCHIP, default 6, number of chip read cycles per channel (legal 1..8).
REQ-003 Parameter WAIT_CNT, default 4, number of pre-read wait cycles (legal >=1).
REQ-004 Parameter L1A_CNT, default 2, number of L1A FIFO read cycles (legal >=1).
REQ-005 Parameter PDEPTH, default 7, maximum number of queued requests (legal 1..15).
REQ-006 Port CLK, input, 1, sole clock; all flops use its rising edge.
REQ-007 Port RST_B, input, 1, asynchronous active-low reset.
REQ-008 Port RDY, input, 1, one-cycle pulse per sample-ready event (transfer request).
REQ-009 Port JTAG_MODE, input, 1, when high no new transfer may start.
REQ-010 Port CHAN_MASK, input, NCHAN, bit i=1 enables channel i.
REQ-011 Port OVR_CLR, input, 1, synchronous clear of OVR.
REQ-012 Port CHAN, output, 4, channel under read.
REQ-013 Port CHIP, output, 3, chip index under read.
REQ-014 Port L1A_RD_EN, output, 1, L1A FIFO read enable.
REQ-015 Port RDENA, output, 1, sample read enable.
REQ-016 Port BUSY, output, 1, high in every state except IDLE.
REQ-017 Port DONE, output, 1, one-cycle end-of-transfer pulse.
REQ-018 Port OVR, output, 1, sticky request-overflow flag.
REQ-019 Port XSTATE, output, 3, current state code.

Function
REQ-020 States and XSTATE codes: IDLE=0, NEXT_CH=1, L1A_RD=2, RD_ENA=3, STRT=4, WAIT=5; codes 6-7 go to IDLE on the next clock.
REQ-021 All outputs are registered and valid in the cycle the state is occupied.
REQ-022 Pending counter PEND (0..PDEPTH): +1 on RDY, -1 on transfer start, net 0 when both happen in one cycle.
REQ-023 RDY while PEND=PDEPTH with no start in that cycle: PEND holds and OVR is set; OVR clears only on OVR_CLR or reset, and a set in the same cycle as OVR_CLR wins.
REQ-024 Transfer start: in IDLE, or at end of a transfer, when (RDY or PEND>0) and JTAG_MODE=0 and CHAN_MASK!=0 -> WAIT; CHAN_MASK is captured into an internal register at start and used for the whole transfer.
REQ-025 If CHAN_MASK=0 or JTAG_MODE=1, the block stays in IDLE and requests keep accumulating in PEND.
REQ-026 WAIT lasts exactly WAIT_CNT cycles, then L1A_RD for exactly L1A_CNT cycles with L1A_RD_EN=1, then STRT for 1 cycle.
REQ-027 STRT: RDENA=1, CHIP=0, CHAN=lowest enabled channel.
REQ-028 RD_ENA: lasts NCHIP cycles per channel, RDENA=1, CHIP counts 0..NCHIP-1, CHAN held.
REQ-029 After the last RD_ENA cycle: if a higher enabled channel exists -> NEXT_CH (1 cycle, RDENA=1, CHIP=0, CHAN=next enabled channel) -> RD_ENA; otherwise end of transfer.
REQ-030 End of transfer: DONE=1 in the next cycle, and the next state is WAIT per REQ-024 or else IDLE.
REQ-031 JTAG_MODE rising mid-transfer does not abort the transfer; it only blocks the next start.
REQ-032 In IDLE, WAIT and L1A_RD: CHAN=0, CHIP=0, RDENA=0; L1A_RD_EN=0 outside L1A_RD.
REQ-033 Cycles per transfer = WAIT_CNT+L1A_CNT+1+E*NCHIP+(E-1), where E is the number of enabled channels.

Reset
REQ-034 RST_B low at any time, including mid-transfer, forces IDLE immediately and sets every output, PEND, internal counters and the mask register to 0.
REQ-035 The first start after reset release requires a new RDY.

Verification
REQ-036 Defaults, mask 0xFFFF, single RDY at cycle t: BUSY from t+1; L1A_RD_EN high at t+5..t+6; DONE at t+119; channel 15 read last.
REQ-037 Mask 0x8001: channel 0 read for 6 cycles, NEXT_CH with CHAN=15, channel 15 read for 6 cycles; transfer totals 20 cycles.
REQ-038 Eight RDY pulses during one transfer (PDEPTH=7): OVR=1, PEND=7; seven back-to-back transfers follow with no IDLE between them; OVR_CLR then clears OVR.
REQ-039 JTAG_MODE=1 with RDY: stays IDLE, PEND=1; JTAG_MODE drops -> start on the next clock.
REQ-040 RST_B low during RD_ENA: outputs 0 asynchronously; after release the block stays IDLE with PEND=0.
